// File: rtl/hdc_pkg.sv
// Shared types for the hypervector bundling datapath: controller state
// encoding, the default vote-counter type and the per-bit majority rule.
package hdc_pkg;

  localparam int unsigned HDC_CNT_WIDTH = 5;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } bundle_state_t;

  typedef logic [HDC_CNT_WIDTH-1:0] vote_cnt_t;

  // Majority decision for one bit position: strict majority wins, a tie
  // falls back to the supplied tie bit.
  function automatic logic vote_decide(input int unsigned count,
                                       input int unsigned n,
                                       input logic        tie_bit);
    if (2 * count > n) return 1'b1;
    else if (2 * count == n) return tie_bit;
    else return 1'b0;
  endfunction

endpackage

// File: rtl/bundle_vote_lane.sv
// One word lane of the bundler: a vote counter per bit plus thresholding.
// Optional macro BUNDLE_TIEBREAK_EN keeps the first word read so ties take
// the bit of input 0; without it ties resolve to 0.
module bundle_vote_lane
  import hdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter type         cnt_t      = vote_cnt_t
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  acc,
`ifdef BUNDLE_TIEBREAK_EN
  input  logic                  first,
`endif
  input  cnt_t                  n,
  input  logic [DATA_WIDTH-1:0] data_rd,
  output logic [DATA_WIDTH-1:0] result
);

  cnt_t cnt [DATA_WIDTH];

  // Per-bit vote counters: cleared on entry to a read burst, bumped per word.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
      if (reset || clr) cnt[b] <= '0;
      else if (acc) cnt[b] <= cnt[b] + cnt_t'(data_rd[b]);
    end
  end

`ifdef BUNDLE_TIEBREAK_EN
  logic [DATA_WIDTH-1:0] first_word;

  // Capture the word of input 0 for tie resolution.
  always_ff @(posedge clk) begin
    if (reset) first_word <= '0;
    else if (first) first_word <= data_rd;
  end
`endif

  // Threshold each counter against n.
  always_comb begin
    result = '0;
    for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
`ifdef BUNDLE_TIEBREAK_EN
      result[b] = vote_decide(int'(cnt[b]), int'(n), first_word[b]);
`else
      result[b] = vote_decide(int'(cnt[b]), int'(n), 1'b0);
`endif
    end
  end

endmodule

// File: rtl/bundle_majority_mapper.sv
// Bitwise majority bundling of n hypervectors held in a multi-port DPRAM.
// Words are processed NUM_PORTS at a time: n read cycles, a drain cycle for
// the last read's data, then one write cycle per chunk.
// Optional macro BUNDLE_TIEBREAK_EN: ties take the bit of input 0.
module bundle_majority_mapper
  import hdc_pkg::*;
#(
  parameter int unsigned HV_DATA_WIDTH    = 32,
  parameter int unsigned HV_ADDRESS_WIDTH = 5,
  parameter int unsigned NUM_PORTS        = 4,
  parameter int unsigned CNT_WIDTH        = 5
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  valid,
  input  logic [HV_ADDRESS_WIDTH-1:0]           vec_length,
  input  logic [CNT_WIDTH-1:0]                  num_inputs,
  input  logic [HV_ADDRESS_WIDTH-1:0]           hva,
  input  logic [HV_ADDRESS_WIDTH-1:0]           stride,
  input  logic [HV_ADDRESS_WIDTH-1:0]           hvc,
  output logic [NUM_PORTS-1:0]                  we_n,
  output logic [NUM_PORTS*HV_ADDRESS_WIDTH-1:0] address,
  output logic [NUM_PORTS*HV_DATA_WIDTH-1:0]    data_wr,
  input  logic [NUM_PORTS*HV_DATA_WIDTH-1:0]    data_rd,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int unsigned AW = HV_ADDRESS_WIDTH;
  localparam int unsigned DW = HV_DATA_WIDTH;
  localparam int unsigned WW = AW + $clog2(NUM_PORTS + 1);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  bundle_state_t state, state_nx;

  logic [AW-1:0] vl_q, hva_q, stride_q, hvc_q;
  cnt_t          n_q, k_q;
  logic [AW-1:0] off_q;
  logic [WW-1:0] wbase_q;
  logic          err_q;
  logic          rd_vld_q;
  logic          clr_cnt;

  logic [NUM_PORTS-1:0] lane_active;
  logic [AW-1:0]        lane_word   [NUM_PORTS];
  logic [DW-1:0]        lane_result [NUM_PORTS];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end

  // Next-state logic; counters clear on every entry into READ.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (valid) begin
          if (num_inputs == '0 || vec_length == '0) state_nx = DONE;
          else state_nx = READ;
        end
      end
      READ:  if (k_q == n_q - cnt_t'(1)) state_nx = DRAIN;
      DRAIN: state_nx = WRITE;
      WRITE: begin
        if (wbase_q + WW'(NUM_PORTS) < WW'(vl_q)) state_nx = READ;
        else state_nx = DONE;
      end
      DONE:    if (!valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    clr_cnt = (state_nx == READ) && (state != READ);
  end

  // Command latch, read index / stride offset and chunk base tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      vl_q     <= '0;
      hva_q    <= '0;
      stride_q <= '0;
      hvc_q    <= '0;
      n_q      <= '0;
      k_q      <= '0;
      off_q    <= '0;
      wbase_q  <= '0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= (state == READ);
      case (state)
        IDLE: begin
          if (valid) begin
            vl_q     <= vec_length;
            hva_q    <= hva;
            stride_q <= stride;
            hvc_q    <= hvc;
            n_q      <= num_inputs;
            err_q    <= (num_inputs == '0);
            k_q      <= '0;
            off_q    <= '0;
            wbase_q  <= '0;
          end
        end
        READ: begin
          k_q   <= k_q + cnt_t'(1);
          off_q <= off_q + stride_q;
        end
        WRITE: begin
          k_q     <= '0;
          off_q   <= '0;
          wbase_q <= wbase_q + WW'(NUM_PORTS);
        end
        default: ;
      endcase
    end
  end

`ifdef BUNDLE_TIEBREAK_EN
  logic first_q;

  // Marks the cycle in which the word of input 0 returns.
  always_ff @(posedge clk) begin
    if (reset) first_q <= 1'b0;
    else first_q <= (state == READ) && (k_q == '0);
  end
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    logic [WW-1:0] word;
    assign word           = wbase_q + WW'(p);
    assign lane_active[p] = word < WW'(vl_q);
    assign lane_word[p]   = word[AW-1:0];

    bundle_vote_lane #(
      .DATA_WIDTH (DW),
      .cnt_t      (cnt_t)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr_cnt),
      .acc     (rd_vld_q && lane_active[p]),
`ifdef BUNDLE_TIEBREAK_EN
      .first   (first_q && lane_active[p]),
`endif
      .n       (n_q),
      .data_rd (data_rd[p*DW +: DW]),
      .result  (lane_result[p])
    );
  end

  // DPRAM port drive: read addresses during READ, results on active lanes in WRITE.
  always_comb begin
    we_n    = '1;
    address = '0;
    data_wr = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (state == READ) begin
        address[p*AW +: AW] = hva_q + off_q + lane_word[p];
      end else if (state == WRITE && lane_active[p]) begin
        we_n[p]             = 1'b0;
        address[p*AW +: AW] = hvc_q + lane_word[p];
        data_wr[p*DW +: DW] = lane_result[p];
      end
    end
  end

  assign busy = (state == READ) || (state == DRAIN) || (state == WRITE);
  assign done = (state == DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_bundle_majority_mapper.sv
// Self-checking bench for bundle_majority_mapper with a 32-word DPRAM model.
module tb_bundle_majority_mapper;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NP = 4;
  localparam int CW = 5;
  localparam int MW = 32;

  logic                clk = 1'b0;
  logic                reset, valid;
  logic [AW-1:0]       vec_length, hva, stride, hvc;
  logic [CW-1:0]       num_inputs;
  logic [NP-1:0]       we_n;
  logic [NP*AW-1:0]    address;
  logic [NP*DW-1:0]    data_wr, data_rd;
  logic                busy, done, err;

  always #5 clk = ~clk;

  bundle_majority_mapper #(
    .HV_DATA_WIDTH    (DW),
    .HV_ADDRESS_WIDTH (AW),
    .NUM_PORTS        (NP),
    .CNT_WIDTH        (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .vec_length (vec_length),
    .num_inputs (num_inputs),
    .hva        (hva),
    .stride     (stride),
    .hvc        (hvc),
    .we_n       (we_n),
    .address    (address),
    .data_wr    (data_wr),
    .data_rd    (data_rd),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  logic [DW-1:0] mem       [MW];
  logic [DW-1:0] model_mem [MW];

  // DPRAM: one-cycle read latency, write on we_n low.
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      data_rd[p*DW +: DW] <= mem[address[p*AW +: AW]];
      if (!we_n[p]) mem[address[p*AW +: AW]] = data_wr[p*DW +: DW];
    end
  end

  typedef struct packed {
    logic [NP-1:0]    we_n;
    logic             busy;
    logic             done;
    logic             err;
    logic [NP-1:0]    amask;
    logic [NP*AW-1:0] addr;
    logic [NP-1:0]    dmask;
    logic [NP*DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the expected trace.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("we_n", we_n, e.we_n);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("err", err, e.err);
      for (int p = 0; p < NP; p++) begin
        if (e.amask[p]) chk("address", address[p*AW +: AW], e.addr[p*AW +: AW]);
        if (e.dmask[p]) chk("data_wr", data_wr[p*DW +: DW], e.data[p*DW +: DW]);
      end
    end
  end

  // Reference: bitwise majority over n words, processed chunk by chunk.
  task automatic build(input int vl, input int n, input int a, input int s, input int c);
    exp_t          e;
    int            chunks, w, ones;
    logic [DW-1:0] res [NP];
    logic [DW-1:0] wd, w0;
    logic [NP-1:0] act;
    for (int i = 0; i < MW; i++) model_mem[i] = mem[i];
    if (n != 0 && vl != 0) begin
      chunks = (vl + NP - 1) / NP;
      for (int ch = 0; ch < chunks; ch++) begin
        act = '0;
        for (int p = 0; p < NP; p++) begin
          w = ch * NP + p;
          res[p] = '0;
          if (w < vl) begin
            act[p] = 1'b1;
            w0 = model_mem[(a + w) % MW];
            for (int b = 0; b < DW; b++) begin
              ones = 0;
              for (int k = 0; k < n; k++) begin
                wd = model_mem[(a + k * s + w) % MW];
                ones += int'(wd[b]);
              end
              if (2 * ones > n) res[p][b] = 1'b1;
`ifdef BUNDLE_TIEBREAK_EN
              else if (2 * ones == n) res[p][b] = w0[b];
`endif
            end
          end
        end
        for (int k = 0; k < n; k++) begin
          e = '0; e.we_n = '1; e.busy = 1'b1; e.amask = act;
          for (int p = 0; p < NP; p++) e.addr[p*AW +: AW] = AW'((a + k * s + ch * NP + p) % MW);
          q.push_back(e);
        end
        e = '0; e.we_n = '1; e.busy = 1'b1;
        q.push_back(e);
        e = '0; e.we_n = ~act; e.busy = 1'b1; e.amask = act; e.dmask = act;
        for (int p = 0; p < NP; p++) begin
          e.addr[p*AW +: AW] = AW'((c + ch * NP + p) % MW);
          e.data[p*DW +: DW] = res[p];
        end
        q.push_back(e);
        for (int p = 0; p < NP; p++)
          if (act[p]) model_mem[(c + ch * NP + p) % MW] = res[p];
      end
    end
    e = '0; e.we_n = '1; e.done = 1'b1; e.err = (n == 0);
    q.push_back(e);
    e = '0; e.we_n = '1; e.err = (n == 0);
    q.push_back(e);
  endtask

  task automatic run_cmd(input int vl, input int n, input int a, input int s, input int c,
                         output int cyc);
    int guard;
    @(negedge clk);
    vec_length = AW'(vl); num_inputs = CW'(n); hva = AW'(a); stride = AW'(s); hvc = AW'(c);
    valid = 1'b1;
    #1 build(vl, n, a, s, c);
    @(posedge clk);
    #1;
    valid = 1'b0;
    vec_length = AW'($urandom); num_inputs = CW'($urandom); hva = AW'($urandom);
    stride = AW'($urandom); hvc = AW'($urandom);
    cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin cyc = i; break; end
    end
    if (cyc < 0) chk("done_timeout", 0, 1);
    guard = 0;
    while (q.size() > 0 && guard < 50) begin @(negedge clk); guard++; end
    if (q.size() > 0) begin chk("trace_timeout", 0, 1); q.delete(); end
    @(negedge clk);
    for (int i = 0; i < MW; i++) chk("mem", mem[i], model_mem[i]);
  endtask

  task automatic load_034(input int stride_words, input int nvec);
    for (int i = 0; i < MW; i++) mem[i] = '0;
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < nvec; w++)
        mem[k * stride_words + w] = (k == 0) ? 32'hFFFF0000 : (k == 1) ? 32'h0000FFFF : 32'hFFFFFFFF;
  endtask

  initial begin
    int cyc, vl, n, expc;
    reset = 1'b1; valid = 1'b0;
    vec_length = '0; num_inputs = '0; hva = '0; stride = '0; hvc = '0;
    for (int i = 0; i < MW; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_we_n", we_n, 4'hF);
    chk("rst_address", address, 0);
    chk("rst_data_wr", data_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;

    // n=3, four words: every bit has at least two ones.
    load_034(4, 4);
    run_cmd(4, 3, 0, 4, 16, cyc);
    chk("r034_latency", cyc, 5);
    for (int i = 16; i < 20; i++) chk("r034_word", mem[i], 32'hFFFFFFFF);

    // n=2 tie case.
    for (int i = 0; i < MW; i++) mem[i] = '0;
    for (int w = 0; w < 4; w++) begin mem[w] = 32'hF0F0F0F0; mem[4 + w] = 32'hFF00FF00; end
    run_cmd(4, 2, 0, 4, 16, cyc);
    chk("r035_latency", cyc, 4);
`ifdef BUNDLE_TIEBREAK_EN
    for (int i = 16; i < 20; i++) chk("r035_word", mem[i], 32'hF0F0F0F0);
`else
    for (int i = 16; i < 20; i++) chk("r035_word", mem[i], 32'hF000F000);
`endif

    // vec_length=6: partial second chunk.
    load_034(8, 6);
    mem[28] = 32'hDEADBEEF; mem[29] = 32'hCAFEF00D;
    run_cmd(6, 3, 0, 8, 22, cyc);
    chk("r036_latency", cyc, 10);
    for (int i = 22; i < 28; i++) chk("r036_word", mem[i], 32'hFFFFFFFF);
    chk("r036_keep6", mem[28], 32'hDEADBEEF);
    chk("r036_keep7", mem[29], 32'hCAFEF00D);

    // num_inputs=0 with valid held: done holds, err sticks after return to IDLE.
    @(negedge clk);
    vec_length = 5'd4; num_inputs = '0; valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("r037_done", done, 1);
      chk("r037_err", err, 1);
      chk("r037_we_n", we_n, 4'hF);
      chk("r037_busy", busy, 0);
    end
    valid = 1'b0;
    @(negedge clk);
    chk("r037_idle_done", done, 0);
    chk("r037_err_sticky", err, 1);

    // vec_length=0: immediate done without error.
    run_cmd(0, 3, 0, 4, 16, cyc);
    chk("vl0_latency", cyc, 0);

    // Reset in the second READ cycle abandons the command.
    load_034(4, 4);
    @(negedge clk);
    vec_length = 5'd4; num_inputs = 5'd3; hva = '0; stride = 5'd4; hvc = 5'd16; valid = 1'b1;
    @(posedge clk); #1 valid = 1'b0;
    @(negedge clk);
    chk("r038_busy_pre", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("r038_we_n", we_n, 4'hF);
    chk("r038_busy", busy, 0);
    chk("r038_done", done, 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("r038_nowrite", mem[16], 0);
    run_cmd(4, 3, 0, 4, 16, cyc);
    chk("r038_latency", cyc, 5);
    for (int i = 16; i < 20; i++) chk("r038_word", mem[i], 32'hFFFFFFFF);

    // Randomized commands against the reference.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < MW; i++) mem[i] = $urandom;
      vl = int'($urandom_range(0, 12));
      n  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7));
      run_cmd(vl, n, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), cyc);
      expc = (n == 0 || vl == 0) ? 0 : ((vl + NP - 1) / NP) * (n + 2);
      chk("rand_latency", cyc, expc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
